// File: rtl/makestuff_tlp_xcvr_pkg.sv
`default_nettype none
// ============================================================================
// makestuff_tlp_xcvr_pkg
// Shared types for the TLP transceiver: receiver Actions and sender commands.
// Revision: 1.0
// ============================================================================
package makestuff_tlp_xcvr_pkg;

  localparam int ACTION_BITS    = 16;
  localparam int CHUNK_PTR_BITS = 4;

  typedef logic [ACTION_BITS-1:0]    Action;
  typedef logic [CHUNK_PTR_BITS-1:0] F2CChunkPtr;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_DMA = 2'd1,
    CMD_MSI = 2'd2
  } CmdKind;

  typedef struct packed {
    CmdKind     kind;
    Action      act;
    F2CChunkPtr chunk;
  } Cmd;

endpackage
`default_nettype wire

// File: rtl/makestuff_tlp_act_fifo.sv
`default_nettype none
// ============================================================================
// makestuff_tlp_act_fifo
// Synchronous FIFO with full/empty flags; a push while full is accepted only
// when a pop frees a slot in the same cycle.
// Revision: 1.0
// ============================================================================
module makestuff_tlp_act_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk_in,
  input  logic             rstN_in,
  input  logic [WIDTH-1:0] wrData_in,
  input  logic             wrEn_in,
  input  logic             rdEn_in,
  output logic [WIDTH-1:0] rdData_out,
  output logic             full_out,
  output logic             empty_out
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wrPtr;
  logic [DEPTH_LOG2:0] r_rdPtr;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[DEPTH_LOG2] != r_rdPtr[DEPTH_LOG2]) &&
                   (r_wrPtr[DEPTH_LOG2-1:0] == r_rdPtr[DEPTH_LOG2-1:0]);
  assign w_pop   = rdEn_in && !w_empty;
  assign w_push  = wrEn_in && (!w_full || w_pop);

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wrPtr[DEPTH_LOG2-1:0]] <= wrData_in;
    end
  end

  always_ff @(posedge clk_in or negedge rstN_in) begin
    if (!rstN_in) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  assign rdData_out = r_mem[r_rdPtr[DEPTH_LOG2-1:0]];
  assign full_out   = w_full;
  assign empty_out  = w_empty;

endmodule
`default_nettype wire

// File: rtl/makestuff_tlp_sched.sv
`default_nettype none
// ============================================================================
// makestuff_tlp_sched
// Merges receiver Actions, F2C DMA chunk writes and MSI requests into the
// single command stream feeding the TLP sender; tracks the F2C write pointer.
// Revision: 1.0
// ============================================================================
module makestuff_tlp_sched
  import makestuff_tlp_xcvr_pkg::*;
#(
  parameter int ACT_DEPTH_LOG2 = 3,
  parameter int F2C_PTR_BITS   = CHUNK_PTR_BITS,
  parameter int DMA_RUN_MAX    = 4
) (
  input  logic                    pcieClk_in,
  input  logic                    pcieRstN_in,
  input  Action                   actData_in,
  input  logic                    actValid_in,
  input  logic                    f2cReq_in,
  output logic                    f2cGrant_out,
  input  logic [F2C_PTR_BITS-1:0] f2cRdPtr_in,
  output logic [F2C_PTR_BITS-1:0] f2cWrPtr_out,
  input  logic                    msiReq_in,
  output logic                    msiAck_out,
  output Cmd                      cmdData_out,
  output logic                    cmdValid_out,
  input  logic                    cmdReady_in,
  input  logic                    cmdDone_in,
  output logic                    actOverflow_out
);

  localparam int RUN_W = $clog2(DMA_RUN_MAX + 1);
  localparam logic [RUN_W-1:0]        RUN_MAX = RUN_W'(DMA_RUN_MAX);
  localparam logic [RUN_W-1:0]        RUN_ONE = RUN_W'(1);
  localparam logic [F2C_PTR_BITS-1:0] PTR_ONE = F2C_PTR_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } State;

  State                    r_state;
  State                    w_stateNext;
  Cmd                      r_cmd;
  Cmd                      w_cmdNext;
  logic [F2C_PTR_BITS-1:0] r_wrPtr;
  logic [F2C_PTR_BITS-1:0] w_free;
  logic [RUN_W-1:0]        r_runCount;
  logic                    r_f2cGrant;
  logic                    r_msiAck;
  logic                    r_overflow;
  logic                    w_dmaOk;
  logic                    w_grantMsi;
  logic                    w_grantAct;
  logic                    w_grantDma;
  logic                    w_cmdDone;
  logic                    w_actPending;
  logic                    w_bypass;
  logic                    w_fifoPush;
  logic                    w_fifoPop;
  logic                    w_fifoFull;
  logic                    w_fifoEmpty;
  Action                   w_fifoData;
  Action                   w_actHead;

  makestuff_tlp_act_fifo #(
    .WIDTH      (ACTION_BITS),
    .DEPTH_LOG2 (ACT_DEPTH_LOG2)
  ) u_actFifo (
    .clk_in     (pcieClk_in),
    .rstN_in    (pcieRstN_in),
    .wrData_in  (actData_in),
    .wrEn_in    (w_fifoPush),
    .rdEn_in    (w_fifoPop),
    .rdData_out (w_fifoData),
    .full_out   (w_fifoFull),
    .empty_out  (w_fifoEmpty)
  );

  // An Action arriving into an empty buffer can be granted straight through.
  assign w_actPending = !w_fifoEmpty || actValid_in;
  assign w_actHead    = w_fifoEmpty ? actData_in : w_fifoData;
  assign w_bypass     = w_grantAct && w_fifoEmpty;
  assign w_fifoPop    = w_grantAct && !w_fifoEmpty;
  assign w_fifoPush   = actValid_in && !w_bypass;

  assign w_free    = f2cRdPtr_in - r_wrPtr - PTR_ONE;
  assign w_dmaOk   = f2cReq_in && (w_free != '0);
  assign w_cmdDone = (r_state == S_WAIT) && cmdDone_in;

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) r_state <= S_IDLE;
    else              r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_grantMsi  = 1'b0;
    w_grantAct  = 1'b0;
    w_grantDma  = 1'b0;
    w_cmdNext   = r_cmd;
    case (r_state)
      S_IDLE: begin
        // A pending Action with no DMA to run is always covered by the
        // second branch, so no separate fallback Action branch is needed.
        if (msiReq_in) begin
          w_grantMsi = 1'b1;
        end else if (w_actPending && (!w_dmaOk || r_runCount == RUN_MAX)) begin
          w_grantAct = 1'b1;
        end else if (w_dmaOk) begin
          w_grantDma = 1'b1;
        end
        if (w_grantMsi || w_grantAct || w_grantDma) begin
          w_stateNext     = S_ISSUE;
          w_cmdNext       = '0;
          w_cmdNext.kind  = w_grantMsi ? CMD_MSI : (w_grantAct ? CMD_ACT : CMD_DMA);
          w_cmdNext.act   = w_grantAct ? w_actHead : '0;
          w_cmdNext.chunk = w_grantDma ? F2CChunkPtr'(r_wrPtr) : '0;
        end
      end
      S_ISSUE: if (cmdReady_in) w_stateNext = S_WAIT;
      S_WAIT:  if (cmdDone_in)  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      r_cmd      <= '0;
      r_wrPtr    <= '0;
      r_runCount <= '0;
      r_f2cGrant <= 1'b0;
      r_msiAck   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_cmd      <= w_cmdNext;
      r_f2cGrant <= w_grantDma;
      r_msiAck   <= w_cmdDone && (r_cmd.kind == CMD_MSI);
      if (w_cmdDone && r_cmd.kind == CMD_DMA) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_grantAct || w_fifoEmpty) begin
        r_runCount <= '0;
      end else if (w_grantDma && r_runCount != RUN_MAX) begin
        r_runCount <= r_runCount + RUN_ONE;
      end
      if (w_fifoPush && w_fifoFull && !w_fifoPop) r_overflow <= 1'b1;
    end
  end

  assign cmdData_out     = r_cmd;
  assign cmdValid_out    = (r_state == S_ISSUE);
  assign f2cGrant_out    = r_f2cGrant;
  assign f2cWrPtr_out    = r_wrPtr;
  assign msiAck_out      = r_msiAck;
  assign actOverflow_out = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_makestuff_tlp_sched.sv
`default_nettype none
// ============================================================================
// tb_makestuff_tlp_sched
// Directed bench for the TLP scheduler with hand-computed expectations.
// Revision: 1.0
// ============================================================================
module tb_makestuff_tlp_sched;
  import makestuff_tlp_xcvr_pkg::*;

  logic       pcieClk_in = 1'b0;
  logic       pcieRstN_in = 1'b0;
  Action      actData_in = '0;
  logic       actValid_in = 1'b0;
  logic       f2cReq_in = 1'b0;
  logic       f2cGrant_out;
  logic [3:0] f2cRdPtr_in = '0;
  logic [3:0] f2cWrPtr_out;
  logic       msiReq_in = 1'b0;
  logic       msiAck_out;
  Cmd         cmdData_out;
  logic       cmdValid_out;
  logic       cmdReady_in = 1'b0;
  logic       cmdDone_in = 1'b0;
  logic       actOverflow_out;

  int checks = 0;
  int errors = 0;

  makestuff_tlp_sched #(
    .ACT_DEPTH_LOG2 (3),
    .F2C_PTR_BITS   (4),
    .DMA_RUN_MAX    (4)
  ) dut (
    .pcieClk_in      (pcieClk_in),
    .pcieRstN_in     (pcieRstN_in),
    .actData_in      (actData_in),
    .actValid_in     (actValid_in),
    .f2cReq_in       (f2cReq_in),
    .f2cGrant_out    (f2cGrant_out),
    .f2cRdPtr_in     (f2cRdPtr_in),
    .f2cWrPtr_out    (f2cWrPtr_out),
    .msiReq_in       (msiReq_in),
    .msiAck_out      (msiAck_out),
    .cmdData_out     (cmdData_out),
    .cmdValid_out    (cmdValid_out),
    .cmdReady_in     (cmdReady_in),
    .cmdDone_in      (cmdDone_in),
    .actOverflow_out (actOverflow_out)
  );

  always #5 pcieClk_in = ~pcieClk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge pcieClk_in);
    #1;
  endtask

  task automatic doReset;
    pcieRstN_in = 1'b0;
    actValid_in = 1'b0;
    f2cReq_in   = 1'b0;
    msiReq_in   = 1'b0;
    cmdReady_in = 1'b0;
    cmdDone_in  = 1'b0;
    f2cRdPtr_in = '0;
    repeat (2) @(posedge pcieClk_in);
    @(negedge pcieClk_in);
    pcieRstN_in = 1'b1;
    tick();
  endtask

  // Sender model: wait for a command, check it, accept, then signal done.
  task automatic runCmd(input string tag, input CmdKind kind, input Action act,
                        input F2CChunkPtr chunk);
    int n = 0;
    while (cmdValid_out !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".valid"}, 32'(cmdValid_out), 32'd1);
    chk({tag, ".kind"}, 32'(cmdData_out.kind), 32'(kind));
    if (kind == CMD_ACT) chk({tag, ".act"}, 32'(cmdData_out.act), 32'(act));
    if (kind == CMD_DMA) chk({tag, ".chunk"}, 32'(cmdData_out.chunk), 32'(chunk));
    chk({tag, ".grant"}, 32'(f2cGrant_out), 32'(kind == CMD_DMA));
    cmdReady_in = 1'b1;
    tick();
    cmdReady_in = 1'b0;
    chk({tag, ".accepted"}, 32'(cmdValid_out), 32'd0);
    repeat (2) tick();
    cmdDone_in = 1'b1;
    tick();
    cmdDone_in = 1'b0;
    chk({tag, ".ack"}, 32'(msiAck_out), 32'(kind == CMD_MSI));
  endtask

  task automatic idleWatch(input string tag, input int cycles);
    int busy = 0;
    for (int c = 0; c < cycles; c++) begin
      if (cmdValid_out !== 1'b0 || f2cGrant_out !== 1'b0) busy++;
      tick();
    end
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    doReset();
    chk("rst.valid", 32'(cmdValid_out), 32'd0);
    chk("rst.grant", 32'(f2cGrant_out), 32'd0);
    chk("rst.ack", 32'(msiAck_out), 32'd0);
    chk("rst.wrptr", 32'(f2cWrPtr_out), 32'd0);
    chk("rst.cmd", 32'(cmdData_out), 32'd0);
    chk("rst.ovf", 32'(actOverflow_out), 32'd0);

    // Single Action with idle sender: valid one cycle after the strobe
    actData_in  = 16'hA5A5;
    actValid_in = 1'b1;
    tick();
    actValid_in = 1'b0;
    chk("t1.latency", 32'(cmdValid_out), 32'd1);
    runCmd("t1.act", CMD_ACT, 16'hA5A5, '0);
    idleWatch("t1.nodup", 6);

    // F2C ring: 15 free chunks from rd=0, then stall, then 5 more after rd=5
    doReset();
    f2cReq_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      runCmd($sformatf("t2.dma%0d", i), CMD_DMA, '0, F2CChunkPtr'(i));
    end
    idleWatch("t2.stall", 10);
    chk("t2.wrptr15", 32'(f2cWrPtr_out), 32'd15);
    f2cRdPtr_in = 4'd5;
    for (int i = 0; i < 5; i++) begin
      runCmd($sformatf("t2.wrap%0d", i), CMD_DMA, '0, F2CChunkPtr'((15 + i) % 16));
    end
    idleWatch("t2.stall2", 8);
    chk("t2.wrptr4", 32'(f2cWrPtr_out), 32'd4);
    f2cReq_in = 1'b0;

    // Reset while a DMA (chunk 4) is in S_WAIT
    f2cRdPtr_in = 4'd10;
    f2cReq_in   = 1'b1;
    tick();
    f2cReq_in = 1'b0;
    chk("t5.valid", 32'(cmdValid_out), 32'd1);
    chk("t5.chunk", 32'(cmdData_out.chunk), 32'd4);
    cmdReady_in = 1'b1;
    tick();
    cmdReady_in = 1'b0;
    pcieRstN_in = 1'b0;
    #1;
    chk("t5.rst.wrptr", 32'(f2cWrPtr_out), 32'd0);
    chk("t5.rst.valid", 32'(cmdValid_out), 32'd0);
    chk("t5.rst.cmd", 32'(cmdData_out), 32'd0);
    chk("t5.rst.grant", 32'(f2cGrant_out), 32'd0);
    @(negedge pcieClk_in);
    pcieRstN_in = 1'b1;
    tick();
    cmdDone_in = 1'b1;
    tick();
    cmdDone_in = 1'b0;
    chk("t5.lateDone.wrptr", 32'(f2cWrPtr_out), 32'd0);
    idleWatch("t5.after", 4);

    // MSI priority and DMA/Action interleave
    doReset();
    msiReq_in = 1'b1;
    tick();
    msiReq_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      actData_in  = Action'(16'h0011 * (i + 1));
      actValid_in = 1'b1;
      tick();
    end
    actValid_in = 1'b0;
    f2cReq_in   = 1'b1;
    msiReq_in   = 1'b1;
    runCmd("t3.msi1", CMD_MSI, '0, '0);
    tick();
    msiReq_in = 1'b0;
    runCmd("t3.msi2", CMD_MSI, '0, '0);
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 4; d++) begin
        runCmd($sformatf("t3.r%0d.dma%0d", r, d), CMD_DMA, '0, F2CChunkPtr'(r * 4 + d));
      end
      if (r == 2) f2cReq_in = 1'b0;
      runCmd($sformatf("t3.r%0d.act", r), CMD_ACT, Action'(16'h0011 * (r + 1)), '0);
    end
    chk("t3.wrptr", 32'(f2cWrPtr_out), 32'd12);
    idleWatch("t3.end", 5);

    // Overflow: 9 Actions while a stalled MSI occupies the sender
    doReset();
    msiReq_in = 1'b1;
    tick();
    msiReq_in = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      actData_in  = Action'(16'h0100 + i);
      actValid_in = 1'b1;
      tick();
      if (i == 8) chk("t4.ovf8", 32'(actOverflow_out), 32'd0);
    end
    actValid_in = 1'b0;
    chk("t4.ovf9", 32'(actOverflow_out), 32'd1);
    runCmd("t4.msi", CMD_MSI, '0, '0);
    for (int i = 1; i <= 8; i++) begin
      runCmd($sformatf("t4.act%0d", i), CMD_ACT, Action'(16'h0100 + i), '0);
    end
    idleWatch("t4.dropped", 6);
    chk("t4.sticky", 32'(actOverflow_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
